// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the FSM encoding, access size codes and the IO window prefix.
package mem_ctrl_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] IO_PREFIX_DEFAULT = 2'b11;

  // Size code 2'b11 is treated as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Responder for the ROB memory port: serialises one load or store per request
// onto the byte-wide RAM/IO bus and returns a one-cycle completion pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [1:0] IO_PREFIX = IO_PREFIX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              RN,
  input  logic              WN,
  input  logic [DATA_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wvalue,
  input  logic [1:0]        Size,
  input  logic              Sign,
  output logic              Mem_Success,
  output logic [DATA_W-1:0] Read_Value,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [DATA_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  output logic [1:0]        dbg_state
);

  // Request handshake: RN/WN are level requests held by the ROB until it sees
  // Mem_Success (one cycle, in DONE); WN wins over RN; DONE ignores requests.

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [DATA_W-1:0] rbuf_q, rbuf_d;
  logic [DATA_W-1:0] rvalue_q, rvalue_d;
  logic              success_q, success_d;
  logic [DATA_W-1:0] mem_a_q, mem_a_d;
  logic [7:0]        mem_dout_q, mem_dout_d;
  logic              wr_q, wr_d;

  logic [2:0]        n_q;
  logic [2:0]        idx_inc;
  logic [1:0]        last_lane;
  logic [1:0]        smp_lane;
  logic [DATA_W-1:0] merged;
  logic              io_req_stall;
  logic              io_cur_stall;

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                               input logic [1:0] sz,
                                               input logic sg);
    case (sz)
      SZ_BYTE: return {{24{sg & v[7]}}, v[7:0]};
      SZ_HALF: return {{16{sg & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  assign n_q          = byte_count(size_q);
  assign idx_inc      = idx_q + 3'd1;
  assign last_lane    = 2'(n_q - 3'd1);
  assign smp_lane     = 2'(idx_q - 3'd1);
  assign io_req_stall = (Addr[17:16] == IO_PREFIX) && io_buffer_full;
  assign io_cur_stall = (addr_q[17:16] == IO_PREFIX) && io_buffer_full;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    sign_d     = sign_q;
    rbuf_d     = rbuf_q;
    rvalue_d   = rvalue_q;
    success_d  = 1'b0;
    mem_a_d    = mem_a_q;
    mem_dout_d = mem_dout_q;
    wr_d       = 1'b0;
    // The final byte bypasses the lane buffer straight from the RAM.
    merged     = rbuf_q;
    merged[{last_lane, 3'b000} +: 8] = mem_din;

    case (state_q)
      S_IDLE: begin
        if (WN) begin
          addr_d     = Addr;
          wdata_d    = Wvalue;
          size_d     = Size;
          mem_a_d    = Addr;
          mem_dout_d = Wvalue[7:0];
          state_d    = S_WR;
          if (io_req_stall) begin
            idx_d = 3'd0;
          end else begin
            wr_d  = 1'b1;
            idx_d = 3'd1;
          end
        end else if (RN) begin
          addr_d  = Addr;
          size_d  = Size;
          sign_d  = Sign;
          mem_a_d = Addr;
          idx_d   = 3'd0;
          state_d = S_RD;
        end
      end
      // idx counts addresses already presented; mem_din lags them by one lane.
      S_RD: begin
        if (idx_q == n_q) begin
          rvalue_d  = extend(merged, size_q, sign_q);
          success_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          if (idx_q != 3'd0) begin
            rbuf_d[{smp_lane, 3'b000} +: 8] = mem_din;
          end
          idx_d = idx_inc;
          if (idx_inc < n_q) begin
            mem_a_d = addr_q + {29'd0, idx_inc};
          end
        end
      end
      // idx counts bytes already strobed; the edge after the last one completes.
      S_WR: begin
        if (idx_q == n_q) begin
          success_d = 1'b1;
          state_d   = S_DONE;
        end else if (!io_cur_stall) begin
          mem_a_d    = addr_q + {29'd0, idx_q};
          mem_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
          wr_d       = 1'b1;
          idx_d      = idx_inc;
        end
      end
      S_DONE: begin
        idx_d   = 3'd0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= 3'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= SZ_BYTE;
      sign_q     <= 1'b0;
      rbuf_q     <= '0;
      rvalue_q   <= '0;
      success_q  <= 1'b0;
      mem_a_q    <= '0;
      mem_dout_q <= 8'd0;
      wr_q       <= 1'b0;
    end else if (rdy) begin
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      rbuf_q     <= rbuf_d;
      rvalue_q   <= rvalue_d;
      success_q  <= success_d;
      mem_a_q    <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      wr_q       <= wr_d;
    end
  end

  assign Mem_Success = success_q;
  assign Read_Value  = rvalue_q;
  assign mem_a       = mem_a_q;
  assign mem_dout    = mem_dout_q;
  assign mem_wr      = wr_q & rdy;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM, transaction-level golden memory,
// per-cycle compare of write beats and completions, directed and random traffic.
module tb_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        RN;
  logic        WN;
  logic [31:0] Addr;
  logic [31:0] Wvalue;
  logic [1:0]  Size;
  logic        Sign;
  logic        Mem_Success;
  logic [31:0] Read_Value;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [39:0] exp_q[$];
  logic [32:0] txn_q[$];

  logic [7:0] ram  [logic [31:0]];
  logic [7:0] gold [logic [31:0]];

  mem_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .RN             (RN),
    .WN             (WN),
    .Addr           (Addr),
    .Wvalue         (Wvalue),
    .Size           (Size),
    .Sign           (Sign),
    .Mem_Success    (Mem_Success),
    .Read_Value     (Read_Value),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .io_buffer_full (io_buffer_full),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] gold_rd(input logic [31:0] a);
    return gold.exists(a) ? gold[a] : init_byte(a);
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz,
                                             input bit sg);
    int n = nbytes(sz);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(gold_rd(a + 32'(i))) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // RAM with one cycle of read latency
  always @(posedge clk) begin
    mem_din <= ram_rd(mem_a);
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a]  = b;
    gold[a] = b;
  endtask

  // scoreboard compare, every cycle out of reset
  always @(negedge clk) begin
    if (rst) begin
      if (mem_wr) begin
        chk("wr_while_not_rdy", {63'd0, ~rdy}, 64'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'd0, mem_a, mem_dout}, 64'd0);
        end else begin
          logic [39:0] e;
          e = exp_q.pop_front();
          chk("write_beat", {24'd0, mem_a, mem_dout}, {24'd0, e});
        end
      end
      if (Mem_Success) begin
        if (txn_q.size() == 0) begin
          chk("unexpected_success", 64'd1, 64'd0);
        end else begin
          logic [32:0] t;
          t = txn_q.pop_front();
          if (t[32]) chk("read_value", {32'd0, Read_Value}, {32'd0, t[31:0]});
        end
      end
    end
  end

  // driver: one complete request, released in DONE
  task automatic access(input bit wn, input bit rn, input logic [31:0] a,
                        input logic [31:0] wv, input logic [1:0] sz, input bit sg,
                        input int exp_lat, output logic [31:0] rv);
    int n = nbytes(sz);
    int cyc = 0;
    if (wn) begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({a + 32'(i), wv[8*i +: 8]});
        gold[a + 32'(i)] = wv[8*i +: 8];
      end
      txn_q.push_back({1'b0, 32'd0});
    end else begin
      txn_q.push_back({1'b1, model_load(a, sz, sg)});
    end
    @(posedge clk);
    #2;
    WN = wn; RN = rn; Addr = a; Wvalue = wv; Size = sz; Sign = sg;
    do begin
      @(negedge clk);
      cyc++;
    end while (!Mem_Success && cyc < 64);
    chk("latency", 64'(cyc - 1), 64'(exp_lat));
    rv = Read_Value;
    @(posedge clk);
    #2;
    WN = 1'b0; RN = 1'b0;
    @(negedge clk);
    chk("pulse_width", {63'd0, Mem_Success}, 64'd0);
  endtask

  initial begin
    logic [31:0] rv;
    logic [31:0] a0;
    int cyc;
    rst = 1'b0; rdy = 1'b1; RN = 1'b0; WN = 1'b0; Addr = '0; Wvalue = '0;
    Size = 2'b00; Sign = 1'b0; io_buffer_full = 1'b0; mem_din = 8'd0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_success", {63'd0, Mem_Success}, 64'd0);
    chk("rst_read_value", {32'd0, Read_Value}, 64'd0);
    chk("rst_mem_a", {32'd0, mem_a}, 64'd0);
    chk("rst_mem_dout", {56'd0, mem_dout}, 64'd0);
    chk("rst_mem_wr", {63'd0, mem_wr}, 64'd0);
    chk("rst_state", {62'd0, dbg_state}, 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // loads with known contents
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    poke(32'h40, 8'h80);  poke(32'h42, 8'h01);  poke(32'h43, 8'h80);
    access(0, 1, 32'h100, 32'd0, 2'b10, 0, 6, rv);
    chk("word_read", {32'd0, rv}, 64'h4433_2211);
    access(0, 1, 32'h40, 32'd0, 2'b00, 1, 3, rv);
    chk("byte_sext", {32'd0, rv}, 64'hFFFF_FF80);
    access(0, 1, 32'h40, 32'd0, 2'b00, 0, 3, rv);
    chk("byte_zext", {32'd0, rv}, 64'h0000_0080);
    access(0, 1, 32'h42, 32'd0, 2'b01, 1, 4, rv);
    chk("half_sext", {32'd0, rv}, 64'hFFFF_8001);

    // word store and read back
    access(1, 0, 32'h200, 32'hDEAD_BEEF, 2'b10, 0, 5, rv);
    access(0, 1, 32'h200, 32'd0, 2'b11, 0, 6, rv);
    chk("store_readback", {32'd0, rv}, 64'hDEAD_BEEF);

    // IO store held off by a full buffer for three edges
    fork
      begin
        @(posedge clk);
        #2;
        io_buffer_full = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        io_buffer_full = 1'b0;
      end
    join_none
    access(1, 0, 32'h0003_0000, 32'h0000_0041, 2'b00, 0, 5, rv);
    access(0, 1, 32'h0003_0000, 32'd0, 2'b00, 0, 3, rv);
    chk("io_readback", {32'd0, rv}, 64'h41);

    // both requests: the write wins
    access(1, 1, 32'h600, 32'hCAFE_F00D, 2'b10, 1, 5, rv);
    access(0, 1, 32'h600, 32'd0, 2'b10, 0, 6, rv);
    chk("rnwn_readback", {32'd0, rv}, 64'hCAFE_F00D);

    // request held through DONE is taken again only afterwards
    txn_q.push_back({1'b1, 32'h4433_2211});
    txn_q.push_back({1'b1, 32'h4433_2211});
    @(posedge clk);
    #2;
    RN = 1'b1; Addr = 32'h100; Size = 2'b10; Sign = 1'b0;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!Mem_Success && cyc < 64);
    chk("held_first_latency", 64'(cyc - 1), 64'd6);
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!Mem_Success && cyc < 64);
    chk("held_reaccept_gap", 64'(cyc), 64'd7);
    @(posedge clk);
    #2;
    RN = 1'b0;
    @(negedge clk);
    chk("held_pulse_width", {63'd0, Mem_Success}, 64'd0);

    // rdy low for two edges in the middle of a store
    fork
      begin
        repeat (3) @(posedge clk);
        #2;
        a0 = mem_a;
        rdy = 1'b0;
        chk("rdy_frozen_addr", {32'd0, a0}, 64'h301);
        repeat (2) begin
          @(negedge clk);
          chk("rdy_low_wr", {63'd0, mem_wr}, 64'd0);
          chk("rdy_low_addr", {32'd0, mem_a}, {32'd0, a0});
        end
        @(posedge clk);
        #2;
        rdy = 1'b1;
      end
    join_none
    access(1, 0, 32'h300, 32'h1234_5678, 2'b10, 0, 7, rv);
    access(0, 1, 32'h300, 32'd0, 2'b10, 0, 6, rv);
    chk("rdy_readback", {32'd0, rv}, 64'h1234_5678);

    // reset in the middle of a word load
    @(posedge clk);
    #2;
    RN = 1'b1; Addr = 32'h500; Size = 2'b10; Sign = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0; RN = 1'b0;
    #1;
    chk("abort_success", {63'd0, Mem_Success}, 64'd0);
    chk("abort_mem_a", {32'd0, mem_a}, 64'd0);
    chk("abort_read_value", {32'd0, Read_Value}, 64'd0);
    chk("abort_state", {62'd0, dbg_state}, 64'd0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort_no_success", {63'd0, Mem_Success}, 64'd0);
    end

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      int k;
      int sel;
      bit wn;
      bit rn;
      logic [31:0] a;
      logic [1:0] sz;
      k   = $urandom_range(0, 99);
      wn  = (k < 40) || (k >= 85);
      rn  = (k >= 40);
      sz  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'h1000 + 32'($urandom_range(0, 63));
      else if (sel == 7) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else if (sel == 8) a = 32'h0003_0000 + 32'($urandom_range(0, 7));
      else               a = $urandom;
      access(wn, rn, a, $urandom, sz, 1'($urandom_range(0, 1)),
             wn ? nbytes(sz) + 1 : nbytes(sz) + 2, rv);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // final report
    repeat (3) @(posedge clk);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("pending_txns", 64'(txn_q.size()), 64'd0);
    foreach (gold[a]) chk("ram_contents", {56'd0, ram_rd(a)}, {56'd0, gold[a]});
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
